// File: rtl/calc_arbiter.sv
// calc_arbiter: round-robin transaction arbiter sharing one calculator among N_REQ requesters
module calc_arbiter #(
    parameter int          N_REQ     = 2,
    parameter int          DEPTH     = 16,
    parameter logic [19:0] IDLE_WORD = 20'h8_0000
) (
    input  logic                 ck,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     wr_valid,
    input  logic [20*N_REQ-1:0]  wr_data,
    output logic [N_REQ-1:0]     wr_ready,
    output logic [19:0]          calc_data,
    input  logic [15:0]          calc_result,
    input  logic                 calc_correct,
    input  logic [3:0]           calc_flags,
    output logic [N_REQ-1:0]     rsp_valid,
    output logic [15:0]          rsp_result,
    output logic                 rsp_correct,
    output logic [3:0]           rsp_flags,
    output logic                 rsp_abort,
    output logic                 busy,
    output logic [1:0]           owner
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, STREAM, CAPTURE} state_t;

    state_t           r_state, w_next;
    logic [1:0]       r_owner, r_rr, w_win, w_sel;
    logic [19:0]      r_calc, w_head;
    logic [19:0]      w_heads [N_REQ];
    logic [N_REQ-1:0] w_full, w_elig, w_cand, w_flush, r_valid;
    logic             w_any, w_pop_any;
    logic [15:0]      r_result;
    logic             r_correct, r_abort;
    logic [3:0]       r_flags;

    for (genvar i = 0; i < N_REQ; i++) begin : g_fifo
        localparam logic [1:0] K = 2'(i);
        logic [19:0]   r_mem [DEPTH];
        logic [AW-1:0] r_wr, r_rd;
        logic [CW-1:0] r_cnt, r_done;
        logic          w_push, w_pop, w_push_done, w_pop_done;
        assign w_push      = wr_valid[i] && !w_full[i];
        assign w_pop       = w_pop_any && (w_sel == K);
        assign w_push_done = w_push && wr_data[20*i+19];
        assign w_pop_done  = w_pop && w_heads[i][19];
        assign w_heads[i]  = r_mem[r_rd];
        assign w_full[i]   = r_cnt[AW];
        assign w_elig[i]   = r_done != '0;
        assign w_cand[i]   = w_full[i] && !w_elig[i] && !(busy && r_owner == K);
        // word storage; contents need no reset since occupancy gates every read
        always_ff @(posedge ck) begin
            if (w_push) r_mem[r_wr] <= wr_data[20*i +: 20];
        end
        // pointers, occupancy and buffered done-word count; a flush empties the FIFO
        always_ff @(posedge ck or posedge rst) begin
            if (rst) begin
                r_wr   <= '0;
                r_rd   <= '0;
                r_cnt  <= '0;
                r_done <= '0;
            end else if (w_flush[i]) begin
                r_rd   <= r_wr;
                r_cnt  <= '0;
                r_done <= '0;
            end else begin
                r_wr   <= r_wr + AW'(w_push);
                r_rd   <= r_rd + AW'(w_pop);
                r_cnt  <= r_cnt + CW'(w_push) - CW'(w_pop);
                r_done <= r_done + CW'(w_push_done) - CW'(w_pop_done);
            end
        end
    end

    // round-robin pick: eligible requester closest to r_rr in search order
    always_comb begin
        int best;
        best  = N_REQ;
        w_win = '0;
        for (int i = 0; i < N_REQ; i++) begin
            int d;
            d = (i + N_REQ - int'(r_rr)) % N_REQ;
            if (w_elig[i] && d < best) begin
                best  = d;
                w_win = 2'(i);
            end
        end
        w_any = best < N_REQ;
    end

    assign w_sel     = (r_state == IDLE) ? w_win : r_owner;
    assign w_pop_any = (r_state == IDLE && w_any) || r_state == STREAM;
    assign w_flush   = (r_state == CAPTURE) ? '0 : w_cand & (~w_cand + N_REQ'(1));

    // head word of the FIFO being granted or streamed
    always_comb begin
        w_head = w_heads[0];
        for (int i = 1; i < N_REQ; i++) w_head = (w_sel == 2'(i)) ? w_heads[i] : w_head;
    end

    // next state: a popped done word always leads to CAPTURE
    always_comb begin
        w_next = IDLE;
        case (r_state)
            IDLE:    w_next = w_any ? (w_head[19] ? CAPTURE : STREAM) : IDLE;
            STREAM:  w_next = w_head[19] ? CAPTURE : STREAM;
            default: w_next = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge ck or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // calculator word, grant bookkeeping and response capture (calc result or abort)
    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            r_calc    <= IDLE_WORD;
            r_owner   <= '0;
            r_rr      <= '0;
            r_valid   <= '0;
            r_result  <= '0;
            r_correct <= 1'b0;
            r_flags   <= '0;
            r_abort   <= 1'b0;
        end else begin
            r_valid <= '0;
            r_calc  <= w_pop_any ? w_head : IDLE_WORD;
            if (r_state == IDLE && w_any) r_owner <= w_win;
            if (r_state == CAPTURE) begin
                r_rr      <= (r_owner == 2'(N_REQ-1)) ? 2'd0 : r_owner + 2'd1;
                r_valid   <= N_REQ'(1) << r_owner;
                r_result  <= calc_result;
                r_correct <= calc_correct;
                r_flags   <= calc_flags;
                r_abort   <= 1'b0;
            end else if (|w_flush) begin
                r_valid   <= w_flush;
                r_result  <= '0;
                r_correct <= 1'b0;
                r_flags   <= '0;
                r_abort   <= 1'b1;
            end
        end
    end

    assign wr_ready    = ~w_full;
    assign calc_data   = r_calc;
    assign rsp_valid   = r_valid;
    assign rsp_result  = r_result;
    assign rsp_correct = r_correct;
    assign rsp_flags   = r_flags;
    assign rsp_abort   = r_abort;
    assign busy        = r_state != IDLE;
    assign owner       = r_owner;
endmodule

// File: tb/tb_calc_arbiter.sv
// tb_calc_arbiter: directed self-checking bench for calc_arbiter
module tb_calc_arbiter;
    logic        ck = 1'b0, rst = 1'b1;
    logic [1:0]  wr_valid = '0;
    logic [39:0] wr_data = '0;
    logic [1:0]  wr_ready, rsp_valid, owner;
    logic [19:0] calc_data;
    logic [15:0] calc_result, rsp_result;
    logic        calc_correct, rsp_correct, rsp_abort, busy;
    logic [3:0]  calc_flags, rsp_flags;
    logic [15:0] m_result = 16'd8;
    logic        m_correct = 1'b1;
    logic [3:0]  m_flags = 4'd0;
    logic        seen;
    int          checks = 0, failures = 0;
    logic [19:0] seq [4] = '{20'h1_0005, 20'h2_0003, 20'h4_0001, 20'h8_0000};

    calc_arbiter dut (
        .ck(ck), .rst(rst), .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
        .calc_data(calc_data), .calc_result(calc_result), .calc_correct(calc_correct),
        .calc_flags(calc_flags), .rsp_valid(rsp_valid), .rsp_result(rsp_result),
        .rsp_correct(rsp_correct), .rsp_flags(rsp_flags), .rsp_abort(rsp_abort),
        .busy(busy), .owner(owner)
    );

    always #5 ck = ~ck;

    // calculator stand-in: outputs are only meaningful while a done word is on the bus
    assign calc_result  = (busy && calc_data[19]) ? m_result : 16'hDEAD;
    assign calc_correct = (busy && calc_data[19]) ? m_correct : 1'b0;
    assign calc_flags   = (busy && calc_data[19]) ? m_flags : 4'hF;

    task automatic tick;
        @(posedge ck);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int r, input logic [19:0] w);
        wr_valid = '0;
        wr_valid[r] = 1'b1;
        wr_data[20*r +: 20] = w;
        tick();
        wr_valid = '0;
    endtask

    task automatic push2(input logic [19:0] a, input logic [19:0] b);
        wr_valid = 2'b11;
        wr_data = {b, a};
        tick();
        wr_valid = '0;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        #2;
        rst = 1'b0;
        tick();
    endtask

    initial begin
        @(posedge ck);
        #1;
        chk("rst_calc", calc_data, 20'h8_0000);
        chk("rst_busy", busy, 0);
        chk("rst_owner", owner, 0);
        chk("rst_valid", rsp_valid, 0);
        chk("rst_abort", rsp_abort, 0);
        chk("rst_result", rsp_result, 0);
        chk("rst_ready", wr_ready, 2'b11);
        rst = 1'b0;
        tick();

        for (int k = 0; k < 4; k++) push(0, seq[k]);
        chk("t1_latency", calc_data, 20'h8_0000);
        tick(); chk("t1_w0", calc_data, 20'h1_0005); chk("t1_busy", busy, 1); chk("t1_owner", owner, 0);
        tick(); chk("t1_w1", calc_data, 20'h2_0003);
        tick(); chk("t1_w2", calc_data, 20'h4_0001);
        tick(); chk("t1_w3", calc_data, 20'h8_0000); chk("t1_novalid", rsp_valid, 0);
        tick();
        chk("t1_valid", rsp_valid, 2'b01);
        chk("t1_result", rsp_result, 8);
        chk("t1_correct", rsp_correct, 1);
        chk("t1_flags", rsp_flags, 0);
        chk("t1_abort", rsp_abort, 0);
        chk("t1_idle", busy, 0);
        tick(); chk("t1_pulse", rsp_valid, 0); chk("t1_hold", rsp_result, 8);

        do_reset();
        push2(20'h1_0002, 20'h1_0007);
        push2(20'h8_0000, 20'h8_0000);
        tick(); chk("c_first", calc_data, 20'h1_0002); chk("c_own0", owner, 0);
        tick(); chk("c_done0", calc_data, 20'h8_0000);
        tick(); chk("c_rsp0", rsp_valid, 2'b01); chk("c_gap", calc_data, 20'h8_0000);
        tick(); chk("c_second", calc_data, 20'h1_0007); chk("c_own1", owner, 1);
        tick();
        tick(); chk("c_rsp1", rsp_valid, 2'b10);
        push2(20'h1_0002, 20'h1_0007);
        push2(20'h8_0000, 20'h8_0000);
        tick(); chk("c_again", calc_data, 20'h1_0002); chk("c_again_own", owner, 0);
        tick();
        tick(); chk("c_again_rsp0", rsp_valid, 2'b01);
        tick();
        tick();
        tick(); chk("c_again_rsp1", rsp_valid, 2'b10);

        push(0, 20'h1_0005);
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("s_stall", calc_data, 20'h8_0000);
        end
        push(0, 20'h2_0003);
        push(0, 20'h4_0001);
        push(0, 20'h8_0000);
        chk("s_wait", calc_data, 20'h8_0000);
        tick(); chk("s_w0", calc_data, 20'h1_0005);
        tick(); chk("s_w1", calc_data, 20'h2_0003);
        tick(); chk("s_w2", calc_data, 20'h4_0001);
        tick(); chk("s_w3", calc_data, 20'h8_0000);
        tick(); chk("s_rsp", rsp_valid, 2'b01);

        m_result = 16'h8000; m_correct = 1'b0; m_flags = 4'b0100;
        push(0, 20'h1_7FFF);
        push(0, 20'h2_0001);
        push(0, 20'h4_0001);
        push(0, 20'h8_0000);
        repeat (5) tick();
        chk("o_valid", rsp_valid, 2'b01);
        chk("o_correct", rsp_correct, 0);
        chk("o_flags", rsp_flags, 4'b0100);
        chk("o_result", rsp_result, 16'h8000);
        m_result = 16'd8; m_correct = 1'b1; m_flags = 4'd0;

        for (int t = 1; t <= 16; t++) begin
            wr_valid = 2'b10;
            wr_data[39:20] = 20'h2_0001;
            if (t >= 9 && t <= 12) begin
                wr_valid[0] = 1'b1;
                wr_data[19:0] = seq[t-9];
            end
            tick();
            if (t == 13) chk("a_r0_w0", calc_data, 20'h1_0005);
        end
        wr_valid = '0;
        chk("a_full", wr_ready, 2'b01);
        chk("a_capture", calc_data, 20'h8_0000);
        tick();
        chk("a_r0_rsp", rsp_valid, 2'b01);
        chk("a_r0_noabort", rsp_abort, 0);
        chk("a_r0_result", rsp_result, 8);
        chk("a_deferred", wr_ready, 2'b01);
        tick();
        chk("a_valid", rsp_valid, 2'b10);
        chk("a_abort", rsp_abort, 1);
        chk("a_result", rsp_result, 0);
        chk("a_correct", rsp_correct, 0);
        chk("a_flags", rsp_flags, 0);
        chk("a_empty", wr_ready, 2'b11);
        tick();
        chk("a_pulse", rsp_valid, 0);
        chk("a_hold", rsp_abort, 1);
        chk("a_nogrant", calc_data, 20'h8_0000);

        for (int k = 0; k < 4; k++) push(1, seq[k]);
        tick(); chk("r_w0", calc_data, 20'h1_0005); chk("r_own", owner, 1);
        tick(); chk("r_w1", calc_data, 20'h2_0003);
        #2;
        rst = 1'b1;
        #1;
        chk("r_calc", calc_data, 20'h8_0000);
        chk("r_busy", busy, 0);
        chk("r_owner", owner, 0);
        chk("r_valid", rsp_valid, 0);
        chk("r_abort", rsp_abort, 0);
        chk("r_ready", wr_ready, 2'b11);
        #2;
        rst = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            tick();
            if (rsp_valid != 0 || calc_data != 20'h8_0000) seen = 1'b1;
        end
        chk("r_noresp", seen, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/calc_arbiter.md
# calc_arbiter

Transaction-level arbiter that shares one `calculator` among `N_REQ` requesters. Each requester streams 20-bit calculator words (start … done) into a private FIFO. When a requester has a complete transaction buffered (its done word is enqueued), the arbiter grants it the calculator by round-robin. It then issues that transaction's words back-to-back on the calculator's `data` input, one per clock with no gaps, and returns the calculator's result and error flags to the owning requester. It sits between the client logic and the calculator, and drives the calculator's `data` port exclusively.

## Interface
- `N_REQ`, 2: number of requesters, 2..4.
- `DEPTH`, 16: per-requester FIFO depth in words; power of 2, ≥4.
- `IDLE_WORD`, 20'h8_0000: word driven when no transaction is in flight. It is a done command with opcode 0, so the calculator stays in waitingForStart and its sticky error register is cleared every idle cycle.
- `ck`  in  1  clock; all state updates on posedge.
- `rst`  in  1  asynchronous, active-high reset.
- `wr_valid`  in  N_REQ  per-requester word valid.
- `wr_data`  in  20*N_REQ  per-requester word; slice i is [20*i+19:20*i]; bits [19:16] are the command, [15:0] the data/opcode.
- `wr_ready`  out  N_REQ  FIFO i not full. Decoded from the registered count only; no same-cycle pop bypass.
- `calc_data`  out  20  registered; connects to calculator `data`.
- `calc_result`  in  16  calculator `result`.
- `calc_correct`  in  1  calculator `correct`.
- `calc_flags`  in  4  {unexpectedDone, dataOverflow, stackOverflow, protocolError}.
- `rsp_valid`  out  N_REQ  one-cycle, one-hot response pulse to requester i.
- `rsp_result`  out  16  captured result.
- `rsp_correct`  out  1  captured correct.
- `rsp_flags`  out  4  captured flags, same order as `calc_flags`.
- `rsp_abort`  out  1  response is an abort (FIFO flushed), not a calculation.
- `busy`  out  1  state ≠ IDLE.
- `owner`  out  2  index of the current or last granted requester.

## Operation
- **Enqueue.** A word is written to FIFO i when `wr_valid[i] && wr_ready[i]`. Each FIFO keeps `done_cnt[i]` = number of buffered words with bit 19 set.
  - A push of a done word increments `done_cnt[i]`; a pop of a done word decrements it.
  - A push and a pop of done words in the same cycle leave it unchanged.
- **Eligibility.** Requester i is eligible when `done_cnt[i] > 0`. The arbiter does not check that words are well formed; malformed sequences are reported through the calculator's own flags.
- **Round-robin.** `rr_ptr` (reset 0) holds the highest-priority index. Search order is `rr_ptr`, `rr_ptr+1`, … mod `N_REQ`. After completing a transaction for requester k, `rr_ptr` ← (k+1) mod `N_REQ`.
- **FSM** (reset IDLE):
  - **IDLE**:
    - `calc_data` = `IDLE_WORD`.
    - If any requester is eligible: grant the winner k, set `owner` ← k, pop the head of FIFO k into `calc_data`. Next state is CAPTURE if that word has bit 19 set, otherwise STREAM.
  - **STREAM**: each edge pops the next owner word into `calc_data`. When the popped word has bit 19 set, the next state is CAPTURE.
  - **CAPTURE**: `calc_data` holds the done word and the calculator outputs are valid combinationally. At the edge:
    - register `rsp_result`, `rsp_correct`, `rsp_flags`;
    - set `rsp_abort` ← 0 and `rsp_valid[owner]` ← 1 for one cycle;
    - set `calc_data` ← `IDLE_WORD`, advance `rr_ptr`, and return to IDLE.
- **Abort.** If FIFO i is full, `done_cnt[i] == 0`, and i is not the owner, FIFO i is flushed to empty at the next edge. That edge also produces `rsp_valid[i]` = 1, `rsp_abort` = 1, and `rsp_result`/`rsp_correct`/`rsp_flags` = 0.
  - An abort is never taken on a CAPTURE edge; it is deferred one cycle.
  - With multiple pending aborts, the lowest index is served first, one per cycle.
- A FIFO may be written while it is being streamed.

## Timing
- **Reset values:**
  - `calc_data` = `IDLE_WORD`;
  - `rsp_valid` = 0, `rsp_result` = 0, `rsp_correct` = 0, `rsp_flags` = 0, `rsp_abort` = 0;
  - `busy` = 0, `owner` = 0;
  - all FIFOs empty, so `wr_ready` = all 1s.
- A reset asserted mid-transaction takes effect immediately. The in-flight transaction is lost and no response is issued.
- **Latency.** Eligibility is evaluated from registered `done_cnt`. The earliest grant is the edge after the done word is enqueued. The first word of the transaction appears on `calc_data` after that grant edge.
- **Transaction of L words:**
  - it occupies the calculator for L consecutive cycles;
  - `rsp_valid` is asserted in the cycle after the last of those L cycles;
  - at least one `IDLE_WORD` cycle separates consecutive transactions.
- `rsp_*` holds its value until the next response; only `rsp_valid` is a pulse.

## Test plan
- **Single transaction.** Requester 0 writes 20'h1_0005, 20'h2_0003, 20'h4_0001, 20'h8_0000 with a real calculator attached.
  - Required: `calc_data` shows exactly those four words on consecutive cycles.
  - Then `rsp_valid` = 2'b01, `rsp_result` = 8, `rsp_correct` = 1, `rsp_flags` = 0.
- **Contention.** Both requesters complete a transaction in the same cycle after reset.
  - Required: requester 0 is served first, then requester 1.
  - A repeated simultaneous contest is won by requester 0 again (`rr_ptr` = 0 after serving requester 1).
- **Stalled writer.** Requester 0 writes a start word, idles 10 cycles, then writes the remaining words.
  - Required: `calc_data` stays 20'h8_0000 until the done word is enqueued; afterwards the words are issued gap-free.
- **Overflow passthrough.** Write 20'h1_7FFF, 20'h2_0001, 20'h4_0001, 20'h8_0000.
  - Required: `rsp_correct` = 0 and `rsp_flags` = 4'b0100.
- **Abort.** Requester 1 writes 16 words of 20'h2_0001 with no done word.
  - Required: `wr_ready[1]` drops, and the next edge pulses `rsp_valid[1]` with `rsp_abort` = 1; FIFO 1 is then empty.
  - A transaction from requester 0 in flight at the same time completes unaffected.
- **Reset mid-stream.** Assert `rst` during STREAM.
  - Required: all outputs take their reset values without waiting for a clock edge, and no response is produced.
